// File: rtl/btn_pkg.sv
// Shared encodings for the button conditioner: per-channel FSM states and repeat phase.
package btn_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_ARM     = 2'd1;
    localparam state_t ST_PRESSED = 2'd2;
    localparam state_t ST_DISARM  = 2'd3;

    localparam logic PH_HOLD   = 1'b0;
    localparam logic PH_REPEAT = 1'b1;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, debounce FSM with press/release counter,
// and a hold counter that generates auto-repeat pulses while the button stays pressed.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000,
    parameter int REPEAT_EN       = 1,
    parameter int CNT_W           = 26
) (
    input  logic ClkPort,
    input  logic Reset,
    input  logic raw,
    output logic level,
    output logic pulse,
    output logic pulse_nxt
);

    localparam logic [CNT_W-1:0] DEB_TERM  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_TERM = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RPT_TERM  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             r_meta;
    logic             r_sync;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] r_hold;
    logic [CNT_W-1:0] w_hold_nxt;
    logic [CNT_W-1:0] w_hold_term;
    logic             r_phase;
    logic             w_phase_nxt;
    logic             r_level;
    logic             w_level_nxt;
    logic             r_pulse;
    logic             w_pulse_nxt;

    // NOTE: raw is asynchronous; only r_sync (second flop) may feed any decision logic.
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_state <= ST_IDLE;
        end else begin
            r_meta  <= raw;
            r_sync  <= r_meta;
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (r_sync) w_state_nxt = ST_ARM;
            ST_ARM:     if (!r_sync) w_state_nxt = ST_IDLE;
                        else if (r_cnt == DEB_TERM) w_state_nxt = ST_PRESSED;
            ST_PRESSED: if (!r_sync) w_state_nxt = ST_DISARM;
            ST_DISARM:  if (r_sync) w_state_nxt = ST_PRESSED;
                        else if (r_cnt == DEB_TERM) w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_hold_term = (r_phase == PH_HOLD) ? HOLD_TERM : RPT_TERM;

    // NOTE: every comb output gets a default first so no path leaves a latch behind.
    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_hold_nxt  = r_hold;
        w_phase_nxt = r_phase;
        w_level_nxt = r_level;
        w_pulse_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_level_nxt = 1'b0;
                w_cnt_nxt   = r_sync ? CNT_ONE : '0;
            end
            ST_ARM: begin
                if (!r_sync) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == DEB_TERM) begin
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b1;
                    w_pulse_nxt = 1'b1;
                    w_hold_nxt  = '0;
                    w_phase_nxt = PH_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_PRESSED: begin
                w_level_nxt = 1'b1;
                if (!r_sync) begin
                    w_cnt_nxt = CNT_ONE;
                end else if (REPEAT_EN != 0) begin
                    if (r_hold == w_hold_term) begin
                        w_pulse_nxt = 1'b1;
                        w_hold_nxt  = '0;
                        w_phase_nxt = PH_REPEAT;
                    end else begin
                        w_hold_nxt = r_hold + 1'b1;
                    end
                end
            end
            ST_DISARM: begin
                // A release bounce restarts the hold timing from scratch, silently.
                if (r_sync) begin
                    w_cnt_nxt   = '0;
                    w_hold_nxt  = '0;
                    w_phase_nxt = PH_HOLD;
                end else if (r_cnt == DEB_TERM) begin
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_level_nxt = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            r_cnt   <= '0;
            r_hold  <= '0;
            r_phase <= PH_HOLD;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_hold  <= w_hold_nxt;
            r_phase <= w_phase_nxt;
            r_level <= w_level_nxt;
            r_pulse <= w_pulse_nxt;
        end
    end

    assign level     = r_level;
    assign pulse     = r_pulse;
    assign pulse_nxt = w_pulse_nxt;

endmodule

// File: rtl/btn_conditioner.sv
// Button input conditioner: N_BTN independent debounce channels plus a registered
// any_pulse that rises in the same cycle as the per-channel pulses.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000,
    parameter int REPEAT_EN       = 1,
    parameter int CNT_W           = 26
) (
    input  logic             ClkPort,
    input  logic             Reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse,
    output logic             any_pulse
);

    logic [N_BTN-1:0] w_pulse_nxt;
    logic             r_any;

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES),
            .REPEAT_EN       (REPEAT_EN),
            .CNT_W           (CNT_W)
        ) u_ch (
            .ClkPort   (ClkPort),
            .Reset     (Reset),
            .raw       (btn_raw[g]),
            .level     (btn_level[g]),
            .pulse     (btn_pulse[g]),
            .pulse_nxt (w_pulse_nxt[g])
        );
    end

    // OR the next-cycle pulses so any_pulse lines up with btn_pulse, not one cycle later.
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) r_any <= 1'b0;
        else       r_any <= |w_pulse_nxt;
    end

    assign any_pulse = r_any;

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner: two DUTs (auto-repeat on / off) share stimulus;
// a run-length reference model predicts level and pulses per edge.
module tb_btn_conditioner;

    localparam int N  = 5;
    localparam int D  = 4;
    localparam int H  = 10;
    localparam int R  = 5;
    localparam int CW = 8;

    logic         ClkPort = 1'b0;
    logic         Reset   = 1'b1;
    logic [N-1:0] btn_raw = '0;
    logic [N-1:0] lvl_r, pls_r, lvl_n, pls_n;
    logic         any_r, any_n;

    btn_conditioner #(.N_BTN(N), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R),
                      .REPEAT_EN(1), .CNT_W(CW)) u_dut_rep (
        .ClkPort(ClkPort), .Reset(Reset), .btn_raw(btn_raw),
        .btn_level(lvl_r), .btn_pulse(pls_r), .any_pulse(any_r));

    btn_conditioner #(.N_BTN(N), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R),
                      .REPEAT_EN(0), .CNT_W(CW)) u_dut_norep (
        .ClkPort(ClkPort), .Reset(Reset), .btn_raw(btn_raw),
        .btn_level(lvl_n), .btn_pulse(pls_n), .any_pulse(any_n));

    always #5 ClkPort = ~ClkPort;

    typedef struct packed {
        logic [N-1:0] lvl_r;
        logic [N-1:0] pls_r;
        logic         any_r;
        logic [N-1:0] lvl_n;
        logic [N-1:0] pls_n;
        logic         any_n;
    } exp_t;

    exp_t         exp_q[$];
    logic [N-1:0] hist_q[$];
    int           checks = 0;
    int           errors = 0;
    int           cycle  = 0;
    int           m_level [2][N];
    int           m_run   [2][N];
    int           m_anchor[2][N];
    int           pulse_cnt[2][N];
    int           any_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s t=%0t got 0x%0h expected 0x%0h", name, $time, act, req);
        end
    endtask

    function automatic void model_reset();
        for (int v = 0; v < 2; v++)
            for (int i = 0; i < N; i++) begin
                m_level[v][i]  = 0;
                m_run[v][i]    = 0;
                m_anchor[v][i] = 0;
            end
        hist_q = {};
        hist_q.push_back('0);
        hist_q.push_back('0);
    endfunction

    // Level flips once D consecutive opposite synchronised samples are seen; while held,
    // pulses fall at anchor+H and then every R cycles. The sample seen at an edge is the
    // raw value captured two edges earlier.
    function automatic exp_t model_edge(input logic rst, input logic [N-1:0] raw);
        exp_t         e;
        logic [N-1:0] seen;
        logic [N-1:0] lv [2];
        logic [N-1:0] pl [2];
        int           el;
        e = '0;
        if (rst) begin
            model_reset();
            return e;
        end
        seen = hist_q.pop_front();
        hist_q.push_back(raw);
        cycle++;
        for (int v = 0; v < 2; v++) begin
            lv[v] = '0;
            pl[v] = '0;
            for (int i = 0; i < N; i++) begin
                if (m_level[v][i] == 0) begin
                    if (seen[i]) begin
                        m_run[v][i]++;
                        if (m_run[v][i] == D) begin
                            m_level[v][i]  = 1;
                            m_run[v][i]    = 0;
                            m_anchor[v][i] = cycle;
                            pl[v][i]       = 1'b1;
                        end
                    end else begin
                        m_run[v][i] = 0;
                    end
                end else if (!seen[i]) begin
                    m_run[v][i]++;
                    if (m_run[v][i] == D) begin
                        m_level[v][i] = 0;
                        m_run[v][i]   = 0;
                    end
                end else if (m_run[v][i] > 0) begin
                    m_run[v][i]    = 0;
                    m_anchor[v][i] = cycle;
                end else if (v == 0) begin
                    el = cycle - m_anchor[v][i];
                    if (el == H || (el > H && (el - H) % R == 0)) pl[v][i] = 1'b1;
                end
                lv[v][i] = (m_level[v][i] != 0);
            end
        end
        e.lvl_r = lv[0];
        e.pls_r = pl[0];
        e.any_r = |pl[0];
        e.lvl_n = lv[1];
        e.pls_n = pl[1];
        e.any_n = |pl[1];
        return e;
    endfunction

    // Drive at posedge+1, let the edge sample it, and queue the expected post-edge outputs.
    task automatic step(input logic [N-1:0] raw, input logic rst);
        btn_raw = raw;
        Reset   = rst;
        @(posedge ClkPort);
        exp_q.push_back(model_edge(rst, raw));
        #1;
    endtask

    task automatic run(input logic [N-1:0] raw, input int n);
        for (int k = 0; k < n; k++) step(raw, 1'b0);
    endtask

    task automatic clear_counts();
        for (int v = 0; v < 2; v++)
            for (int i = 0; i < N; i++) pulse_cnt[v][i] = 0;
        any_cnt = 0;
    endtask

    // Assert Reset between edges and confirm the asynchronous clear.
    task automatic async_reset(input logic [N-1:0] raw);
        @(negedge ClkPort);
        #1;
        Reset = 1'b1;
        #1;
        check("rst_async_level_rep", 32'(lvl_r), 32'd0);
        check("rst_async_pulse_rep", 32'(pls_r), 32'd0);
        check("rst_async_any_rep", 32'(any_r), 32'd0);
        check("rst_async_level_norep", 32'(lvl_n), 32'd0);
        model_reset();
        step(raw, 1'b1);
        step(raw, 1'b1);
    endtask

    always @(negedge ClkPort) begin
        exp_t e;
        for (int i = 0; i < N; i++) begin
            if (pls_r[i] === 1'b1) pulse_cnt[0][i]++;
            if (pls_n[i] === 1'b1) pulse_cnt[1][i]++;
        end
        if (any_r === 1'b1) any_cnt++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("level_rep", 32'(lvl_r), 32'(e.lvl_r));
            check("pulse_rep", 32'(pls_r), 32'(e.pls_r));
            check("any_rep", 32'(any_r), 32'(e.any_r));
            check("level_norep", 32'(lvl_n), 32'(e.lvl_n));
            check("pulse_norep", 32'(pls_n), 32'(e.pls_n));
            check("any_norep", 32'(any_n), 32'(e.any_n));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [N-1:0] val;
        int           rem [N];
        int           ones;

        model_reset();
        clear_counts();
        for (int k = 0; k < 3; k++) step('0, 1'b1);
        run('0, 4);

        // Clean press on bit 0, held 8 cycles.
        clear_counts();
        run(5'b00001, 8);
        run('0, 12);
        check("clean_press_pulses", 32'(pulse_cnt[0][0]), 32'd1);
        check("clean_press_other", 32'(pulse_cnt[0][1] + pulse_cnt[0][2] + pulse_cnt[0][3] + pulse_cnt[0][4]), 32'd0);

        // Glitch train on bit 1: never D consecutive highs.
        clear_counts();
        begin
            logic [14:0] pat;
            pat = 15'b101101110100110;
            for (int k = 14; k >= 0; k--) step({3'b000, pat[k], 1'b0}, 1'b0);
        end
        for (int k = 0; k < 8; k++) begin
            ones = $urandom_range(1, D - 1);
            run(5'b00010, ones);
            run('0, $urandom_range(1, 2));
        end
        run('0, 6);
        check("glitch_pulses", 32'(pulse_cnt[0][1]), 32'd0);

        // Long hold on bit 2 with a release bounce.
        clear_counts();
        run(5'b00100, 40);
        run('0, 1);
        run(5'b00100, 1);
        run('0, 12);
        check("hold_repeat_pulses", 32'(pulse_cnt[0][2]), 32'd7);
        check("hold_norepeat_pulses", 32'(pulse_cnt[1][2]), 32'd1);

        // Simultaneous press on bits 3 and 4.
        clear_counts();
        run(5'b11000, 6);
        run('0, 8);
        check("simul_pulse3", 32'(pulse_cnt[0][3]), 32'd1);
        check("simul_pulse4", 32'(pulse_cnt[0][4]), 32'd1);
        check("simul_any_cycles", 32'(any_cnt), 32'd1);

        // Reset mid-ARM with bit 0 held high.
        clear_counts();
        run(5'b00001, 4);
        async_reset(5'b00001);
        run(5'b00001, 10);
        run('0, 8);
        check("rst_arm_repress", 32'(pulse_cnt[0][0]), 32'd1);

        // Reset mid-PRESSED with bit 1 held high.
        clear_counts();
        run(5'b00010, 9);
        async_reset(5'b00010);
        run(5'b00010, 10);
        run('0, 8);
        check("rst_pressed_repress", 32'(pulse_cnt[0][1]), 32'd2);

        // Random per-channel run lengths, checked against the model.
        for (int i = 0; i < N; i++) rem[i] = 0;
        val = '0;
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < N; i++) begin
                if (rem[i] == 0) begin
                    val[i] = 1'($urandom_range(0, 1));
                    rem[i] = $urandom_range(1, 25);
                end
                rem[i]--;
            end
            step(val, 1'b0);
        end
        run('0, 12);

        for (int w = 0; w < 5 && exp_q.size() != 0; w++) @(negedge ClkPort);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
